// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue
//
// Instruction-fetch front end. Generates sequential PCs and issues reads to a
// synchronous-read instruction memory with a latency of one cycle. It buffers
// the returned {pc, inst} pairs in a small FIFO and hands them to decode over
// a valid/ready handshake. A redirect from jump or branch resolution flushes
// the queue, drops any read that is still in flight, and restarts fetch at
// the new PC.
//
// Parameters
//   RESET_PC    PC fetched first after reset (bits [1:0] are forced to 0)
//   MEM_AW      instruction memory word-address width
//   FIFO_DEPTH  queue entries (power of 2, >= 2)
//
// Ports
//   clk            in   1       clock, rising edge
//   rst_n          in   1       asynchronous reset, active low
//   redirect_vld   in   1       jump/branch taken; restart fetch at redirect_addr
//   redirect_addr  in   32      new PC; bits [1:0] treated as 0
//   mem_rd_en      out  1       read strobe to instruction memory
//   mem_addr       out  MEM_AW  word address (fetch_pc[MEM_AW+1:2])
//   mem_rdata      in   32      read data, valid the cycle after mem_rd_en
//   out_vld        out  1       queue head valid
//   out_rdy        in   1       decode accepts head this cycle
//   out_pc         out  32      PC of head entry
//   out_inst       out  32      instruction of head entry
//
// Handshake: the head entry transfers on every rising edge where
// out_vld && out_rdy. While out_vld is high and out_rdy is low, out_pc and
// out_inst hold their values. out_vld never depends on out_rdy. A redirect
// in the same cycle overrides the transfer, so that head entry is discarded
// and not consumed.
// ---------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          MEM_AW     = 10,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_vld,
    input  logic [31:0]       redirect_addr,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_inst
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

    // Fetch side
    logic [31:0]      fetch_pc;
    logic [31:0]      inflight_pc;
    logic             inflight;
    logic [31:0]      redirect_pc;

    // Queue storage and control
    logic [31:0]      fifo_pc   [FIFO_DEPTH];
    logic [31:0]      fifo_inst [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [CNT_W-1:0] credit_used;
    logic             issue;
    logic             push;
    logic             pop;

    // -----------------------------------------------------------------------
    // Control
    // -----------------------------------------------------------------------
    assign redirect_pc = redirect_addr & 32'hFFFF_FFFC;

    // Credits: every queued entry and the read in flight each hold one slot.
    // A read is issued only when a slot is free, so a returning read always
    // finds room in the FIFO. No full check is needed on push.
    always_comb begin
        credit_used = count + CNT_W'(inflight);
    end

    // rst_n gates the issue strobe so that mem_rd_en stays low while reset is
    // asserted. Without this gate the empty credit state would enable it.
    assign issue = rst_n && !redirect_vld && (credit_used < DEPTH_CNT);
    assign push  = inflight && !redirect_vld;
    assign pop   = out_vld && out_rdy && !redirect_vld;

    assign mem_rd_en = issue;
    assign mem_addr  = fetch_pc[MEM_AW+1:2];

    // -----------------------------------------------------------------------
    // Fetch PC and in-flight tracking
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC_ALIGNED;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
        end else begin
            if (redirect_vld) begin
                fetch_pc <= redirect_pc;
            end else if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;   // wraps naturally modulo 2^32
            end
            // issue is low during a redirect, so this also clears the flag and
            // causes the returning read to be ignored.
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Queue pointers and occupancy
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_vld) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Queue storage
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc[i]   <= 32'h0;
                fifo_inst[i] <= 32'h0;
            end
        end else if (push) begin
            fifo_pc[wr_ptr]   <= inflight_pc;
            fifo_inst[wr_ptr] <= mem_rdata;
        end
    end

    // -----------------------------------------------------------------------
    // Output: head entry from registers; zero whenever the queue is empty
    // -----------------------------------------------------------------------
    assign out_vld  = (count != '0);
    assign out_pc   = out_vld ? fifo_pc[rd_ptr]   : 32'h0;
    assign out_inst = out_vld ? fifo_inst[rd_ptr] : 32'h0;

endmodule
